// File: rtl/up_down_counter_n_if.sv
// Control and status bundle for up_down_counter_n.
// The master drives the counter controls; the slave (the counter) returns its state.
interface up_down_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             a;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             ovf;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, a, sat, load, load_val, clr_ovf,
    input  count, wrap, ovf, at_max, at_min
  );

  modport slave (
    input  en, a, sat, load, load_val, clr_ovf,
    output count, wrap, ovf, at_max, at_min
  );
endinterface

// File: rtl/up_down_counter_n.sv
// Modulo-(MAX_VAL+1) up/down counter with wrap/saturate boundary modes,
// parallel load, a one-cycle wrap pulse and a sticky boundary-event flag.
module up_down_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (2**WIDTH) - 1,
  parameter int INIT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  up_down_counter_n_if.slave   bus
);

  if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1 ||
      INIT < 0 || INIT > MAX_VAL) begin : g_bad_params
    $error("up_down_counter_n: illegal WIDTH/MAX_VAL/INIT combination");
  end

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    // A boundary step below overrides this clear, so set beats clear.
    if (bus.clr_ovf) ovf_d = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end else if (bus.en) begin
      if (!bus.a) begin
        if (count_q == MAX_C) begin
          ovf_d = 1'b1;
          if (!bus.sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          ovf_d = 1'b1;
          if (!bus.sat) begin
            count_d = MAX_C;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= INIT_C;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.wrap   = wrap_q;
  assign bus.ovf    = ovf_q;
  assign bus.at_max = (count_q == MAX_C);
  assign bus.at_min = (count_q == '0);

endmodule

// File: doc/up_down_counter_n.md
UP_DOWN_COUNTER_N -- requirements
Module: up_down_counter_n

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH    4                count width in bits
  MAX_VAL  (2**WIDTH)-1     highest count value; counter is modulo MAX_VAL+1
  INIT     0                value loaded by reset
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk       input   1      single clock, all state updates on rising edge
  reset     input   1      asynchronous, active-low reset
  en        input   1      count enable
  a         input   1      direction: 0 = count up, 1 = count down
  sat       input   1      boundary mode: 0 = wrap, 1 = saturate
  load      input   1      synchronous parallel load
  load_val  input   WIDTH  value for load
  clr_ovf   input   1      synchronous clear of ovf
  count     output  WIDTH  registered count value
  wrap      output  1      registered pulse marking a wrap step
  ovf       output  1      sticky boundary-event flag
  at_max    output  1      combinational: count == MAX_VAL
  at_min    output  1      combinational: count == 0
REQ-003 Legal parameters SHALL be 1 <= MAX_VAL <= (2**WIDTH)-1 and INIT <= MAX_VAL; the module SHALL stop elaboration with an error on violation.

Function
REQ-004 Per-edge priority for count SHALL be load, then en, then hold.
REQ-005 On load, count SHALL take load_val, clamped to MAX_VAL if load_val > MAX_VAL; wrap SHALL be 0 that cycle; ovf SHALL be unaffected by the load itself.
REQ-006 With en=1, load=0, a=0 and count < MAX_VAL, count SHALL increment by 1.
REQ-007 With en=1, load=0, a=1 and count > 0, count SHALL decrement by 1.
REQ-008 Up at count == MAX_VAL: sat=0 -> count becomes 0 and wrap=1; sat=1 -> count holds MAX_VAL and wrap=0.
REQ-009 Down at count == 0: sat=0 -> count becomes MAX_VAL and wrap=1; sat=1 -> count holds 0 and wrap=0.
REQ-010 wrap SHALL be registered on the same edge as count and be high only during the one cycle count shows the wrapped value; otherwise wrap SHALL be 0, including when en=0.
REQ-011 ovf SHALL set on any REQ-008/REQ-009 boundary step in either mode, SHALL stay set until clr_ovf=1 at an edge, and a set condition SHALL win over a simultaneous clr_ovf.
REQ-012 Changes to a and sat SHALL take effect at the next edge with no added latency; no intermediate state is allowed on a direction reversal.
REQ-013 With en=0 and load=0, count SHALL hold; a, sat and load_val SHALL be ignored.
REQ-014 All arithmetic SHALL be WIDTH bits with no carry beyond WIDTH; count SHALL never leave the range 0..MAX_VAL.
REQ-015 at_max and at_min SHALL be decoded from the registered count only, with no dependency on inputs.

Reset
REQ-016 When reset=0, without waiting for a clock edge: count SHALL be INIT, wrap 0, ovf 0.
REQ-017 While reset=0, all inputs SHALL be ignored.
REQ-018 Counting SHALL resume on the first rising edge of clk after reset returns to 1.
REQ-019 Reset asserted mid-operation, including in a wrap cycle, SHALL discard pending state and the wrap pulse immediately.

Verification
REQ-020 The bench SHALL cover these directed scenarios (WIDTH=4, MAX_VAL=9, INIT=0 unless stated):
  a) Count to 5, drop reset between edges -> count=0, wrap=0, ovf=0 before the next edge.
  b) en=1, a=0, sat=0, 10 edges from 0 -> count 1..9 then 0; wrap=1 only in the 0 cycle; ovf=1; at_max=1 at 9.
  c) count=0, a=1: with sat=0, one edge -> count=9, wrap=1; with sat=1 -> count stays 0, wrap=0, ovf=1.
  d) load=1, load_val=13 -> count=9; load=1, en=1, load_val=4 in the same cycle -> count=4, wrap=0.
  e) clr_ovf=1 on the same edge as a wrap -> ovf stays 1; clr_ovf=1 on the next edge -> ovf=0.
  f) Defaults (WIDTH=4, MAX_VAL=15): up from 15 -> 0 with wrap=1; a toggled every cycle from 7 -> count alternates 8, 7, 8.
